// File: rtl/address_decoder_ws.sv
// Registered memory-map decoder: priority-decodes CPU requests against a window
// table, inserts per-region wait states and completes with an ack/err pulse.

module address_decoder_ws_hit #(
    parameter int ADDR_W = 16
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    // base > limit can never satisfy both bounds, so inverted windows fall out naturally
    assign hit = en && (addr >= base) && (addr <= limit);
endmodule

module address_decoder_ws #(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 8,
    parameter int WAIT_W      = 4,
    parameter int FCNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_req,
    input  logic [ADDR_W-1:0]             cpu_address,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_limit,
    input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
    input  logic [NUM_REGIONS-1:0]        region_enable,
    output logic [NUM_REGIONS-1:0]        select,
    output logic                          cpu_ack,
    output logic                          cpu_err,
    output logic                          busy,
    output logic                          fault_valid,
    output logic [ADDR_W-1:0]             fault_address,
    output logic [FCNT_W-1:0]             fault_count,
    input  logic                          fault_clr
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;

    logic [NUM_REGIONS-1:0][ADDR_W-1:0] base_a, limit_a;
    logic [NUM_REGIONS-1:0][WAIT_W-1:0] wait_a;
    logic [NUM_REGIONS-1:0]             hit;
    logic                               hit_any;
    logic [IDX_W-1:0]                   win_idx;
    logic [NUM_REGIONS-1:0]             win_sel;
    logic [WAIT_W-1:0]                  win_wait;

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;

    assign base_a  = region_base;
    assign limit_a = region_limit;
    assign wait_a  = region_wait;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        address_decoder_ws_hit #(.ADDR_W(ADDR_W)) u_hit (
            .en    (region_enable[i]),
            .base  (base_a[i]),
            .limit (limit_a[i]),
            .addr  (cpu_address),
            .hit   (hit[i])
        );
    end

    // Scan high to low so the lowest hitting index is the last one written
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        win_sel = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        win_sel[win_idx] = hit_any;
        win_wait = wait_a[win_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            select        <= '0;
            cpu_ack       <= 1'b0;
            cpu_err       <= 1'b0;
            busy          <= 1'b0;
            fault_valid   <= 1'b0;
            fault_address <= '0;
            fault_count   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            if (fault_clr && state != S_FAULT) begin
                fault_valid <= 1'b0;
                fault_count <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q <= cpu_address;
                        busy   <= 1'b1;
                        if (hit_any) begin
                            select <= win_sel;
                            if (win_wait != '0) begin
                                cnt   <= win_wait - 1'b1;
                                state <= S_WAIT;
                            end else begin
                                cpu_ack <= 1'b1;
                                state   <= S_DONE;
                            end
                        end else begin
                            cpu_err <= 1'b1;
                            state   <= S_FAULT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        cpu_ack <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    select <= '0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                S_FAULT: begin
                    fault_address <= addr_q;
                    fault_valid   <= 1'b1;
                    // A clear landing on the capture cycle loses to the capture
                    if (fault_clr)
                        fault_count <= FCNT_W'(1);
                    else if (!(&fault_count))
                        fault_count <= fault_count + 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_address_decoder_ws.sv
// Randomised scoreboard bench for address_decoder_ws against a table-lookup reference.

module tb_address_decoder_ws;
    localparam int AW = 16, NR = 8, WW = 4, FW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [AW-1:0]     cpu_address;
    logic [NR*AW-1:0]  region_base, region_limit;
    logic [NR*WW-1:0]  region_wait;
    logic [NR-1:0]     region_enable;
    logic [NR-1:0]     select;
    logic              cpu_ack, cpu_err, busy, fault_valid;
    logic [AW-1:0]     fault_address;
    logic [FW-1:0]     fault_count;
    logic              fault_clr;

    address_decoder_ws #(.ADDR_W(AW), .NUM_REGIONS(NR), .WAIT_W(WW), .FCNT_W(FW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_address(cpu_address),
        .region_base(region_base), .region_limit(region_limit),
        .region_wait(region_wait), .region_enable(region_enable),
        .select(select), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .busy(busy),
        .fault_valid(fault_valid), .fault_address(fault_address),
        .fault_count(fault_count), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] m_base [NR];
    logic [AW-1:0] m_lim  [NR];
    logic [WW-1:0] m_wait [NR];
    logic          m_en   [NR];

    always_comb begin
        region_base   = '0;
        region_limit  = '0;
        region_wait   = '0;
        region_enable = '0;
        for (int i = 0; i < NR; i++) begin
            region_base[i*AW +: AW]  = m_base[i];
            region_limit[i*AW +: AW] = m_lim[i];
            region_wait[i*WW +: WW]  = m_wait[i];
            region_enable[i]         = m_en[i];
        end
    end

    typedef struct {
        bit          is_err;
        logic [NR-1:0] sel;
        int          exp_cyc;
        int          wait_n;
        logic [AW-1:0] f_addr;
        bit          f_valid;
        int          f_cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0, failures = 0;
    logic [AW-1:0] m_faddr = '0;
    bit   m_fvalid = 0;
    int   m_fcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NR; i++)
            if (m_en[i] && a >= m_base[i] && a <= m_lim[i]) return i;
        return -1;
    endfunction

    task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] l,
                              input int w, input bit en);
        m_base[i] = b; m_lim[i] = l; m_wait[i] = WW'(w); m_en[i] = en;
    endtask

    task automatic do_access(input logic [AW-1:0] a, input bit clr);
        exp_t e;
        int   r;
        bit   done;
        @(negedge clk);
        r = ref_decode(a);
        if (r < 0) begin
            m_faddr  = a;
            m_fvalid = 1;
            m_fcnt   = clr ? 1 : ((m_fcnt == 255) ? 255 : m_fcnt + 1);
            e.is_err = 1; e.sel = '0; e.wait_n = 0; e.exp_cyc = cyc + 1;
        end else begin
            e.is_err = 0; e.sel = 8'd1 << r; e.wait_n = int'(m_wait[r]);
            e.exp_cyc = cyc + 1 + int'(m_wait[r]);
        end
        e.f_addr = m_faddr; e.f_valid = m_fvalid; e.f_cnt = m_fcnt;
        q.push_back(e);
        cpu_address = a;
        cpu_req = 1'b1;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            cpu_address = AW'($urandom);
            if (cpu_ack || cpu_err) done = 1;
        end
        cpu_req = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL access_timeout: addr 0x%0h got no ack/err, required one within 40 cycles", a);
        end
        if (clr && cpu_err) begin
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an access
    initial begin
        exp_t e;
        int sel_run = 0, busy_run = 0;
        forever begin
            @(negedge clk);
            sel_run  = (select != '0) ? sel_run + 1 : 0;
            busy_run = busy ? busy_run + 1 : 0;
            if (cpu_ack || cpu_err) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_completion: ack=%0b err=%0b with no access outstanding", cpu_ack, cpu_err);
                end else begin
                    e = q.pop_front();
                    chk("ack", cpu_ack, !e.is_err);
                    chk("err", cpu_err, e.is_err);
                    chk("select", select, e.sel);
                    chk("latency_cycle", cyc, e.exp_cyc);
                    chk("busy_cycles", busy_run, e.wait_n + 1);
                    if (!e.is_err) chk("select_cycles", sel_run, e.wait_n + 1);
                    if (e.is_err) begin
                        @(negedge clk);
                        sel_run = 0; busy_run = 0;
                        chk("fault_address", fault_address, e.f_addr);
                        chk("fault_valid", fault_valid, e.f_valid);
                        chk("fault_count", fault_count, e.f_cnt);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_address = '0; fault_clr = 1'b0;
        for (int i = 0; i < NR; i++) set_region(i, '0, '0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_select", select, 0);
        chk("rst_ack_err_busy", {cpu_ack, cpu_err, busy}, 0);
        chk("rst_fault", {fault_valid, fault_address, fault_count}, 0);
        rst = 1'b0;

        set_region(0, 16'h0000, 16'h3fff, 0, 1);
        set_region(1, 16'h4000, 16'h4fff, 1, 1);
        set_region(2, 16'h4000, 16'h41ff, 0, 1);
        set_region(3, 16'h8000, 16'h8fff, 3, 1);
        set_region(4, 16'h9000, 16'h8000, 0, 1);
        set_region(5, 16'h5000, 16'h6fff, 2, 1);
        set_region(6, 16'ha000, 16'hafff, 1, 0);
        set_region(7, 16'hc000, 16'hffff, 4, 1);

        // Reset mid-WAIT drops the access
        @(negedge clk);
        cpu_address = 16'h8100; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("midwait_busy", busy, 1);
        chk("midwait_select", select, 8'h08);
        rst = 1'b1;
        #1;
        chk("async_rst_select", select, 0);
        chk("async_rst_ack_busy", {cpu_ack, busy}, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        do_access(16'h1234, 0);
        do_access(16'h5abc, 0);
        do_access(16'h4100, 0);
        m_en[1] = 1'b0;
        do_access(16'h4100, 0);
        do_access(16'h4200, 0);
        do_access(16'h7fff, 0);
        do_access(16'h3fff, 0);
        do_access(16'h5000, 0);
        do_access(16'h6fff, 0);
        do_access(16'h9000, 0);
        do_access(16'hc000, 0);
        do_access(16'hffff, 0);
        do_access(16'h8100, 0);
        do_access(16'hafff, 0);

        for (int n = 0; n < 256; n++) do_access(AW'($urandom_range(16'h7000, 16'h7fff)), 0);
        @(negedge clk);
        chk("fault_count_saturated", fault_count, 8'hff);

        do_access(16'h7ff0, 1);
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        m_fvalid = 0; m_fcnt = 0;
        chk("clr_fault_valid", fault_valid, 0);
        chk("clr_fault_count", fault_count, 0);
        chk("clr_keeps_address", fault_address, 16'h7ff0);

        for (int n = 0; n < 150; n++) begin
            if (n % 20 == 0) begin
                for (int i = 0; i < NR; i++) begin
                    logic [AW-1:0] b;
                    b = AW'($urandom);
                    set_region(i, b, b + AW'($urandom_range(0, 16'h3fff)),
                               $urandom_range(0, 5), ($urandom % 4) != 0);
                end
            end
            do_access(AW'($urandom), ($urandom % 4) == 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/address_decoder_ws.md
Name: address_decoder_ws

Overview:
- Parametrised, registered successor to the combinational memory-map decoder.
- Decodes CPU bus requests against a table of NUM_REGIONS windows and drives one-hot region selects.
- Inserts per-region wait states, then completes each access with an ack/err handshake.
- Sits between the CPU bus interface and memory/IO chip selects; unmapped accesses are reported and captured for firmware debug.

Parameters:
- ADDR_W, 16, CPU address width.
- NUM_REGIONS, 8, number of decode windows; index 0 has highest priority.
- WAIT_W, 4, width of each per-region wait-state count.
- FCNT_W, 8, width of the saturating fault counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  access request; held high until cpu_ack or cpu_err.
- cpu_address  input  ADDR_W  access address; sampled only on acceptance.
- region_base  input  NUM_REGIONS*ADDR_W  inclusive lower bound, region i at [i*ADDR_W +: ADDR_W]; quasi-static.
- region_limit  input  NUM_REGIONS*ADDR_W  inclusive upper bound, same packing.
- region_wait  input  NUM_REGIONS*WAIT_W  wait states per region.
- region_enable  input  NUM_REGIONS  per-region enable.
- select  output  NUM_REGIONS  registered one-hot select of the active region.
- cpu_ack  output  1  one-cycle pulse: mapped access complete.
- cpu_err  output  1  one-cycle pulse: unmapped access complete.
- busy  output  1  high while not in IDLE.
- fault_valid  output  1  sticky: an unmapped access was captured.
- fault_address  output  ADDR_W  address of the most recent unmapped access.
- fault_count  output  FCNT_W  saturating count of unmapped accesses.
- fault_clr  input  1  clears fault_valid and fault_count.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, wait counter 0, FSM to IDLE. An in-flight access is dropped with no ack or err.
- Hit rule: region i hits when region_enable[i] is high and base_i <= addr <= limit_i, compared unsigned and inclusive.
  - A region with base > limit never hits.
  - If several regions hit, the lowest index wins; select is always one-hot or zero.
- FSM states: IDLE, WAIT, DONE, FAULT.
- IDLE:
  - cpu_req high at a rising edge accepts the access: the address is latched and the winner decoded in the same cycle.
  - Hit with wait W>0: select[i]=1, counter=W-1, go to WAIT.
  - Hit with W=0: select[i]=1, go to DONE.
  - Miss: go to FAULT; select stays 0.
- WAIT: select held. Counter decrements each cycle; when counter==0, go to DONE.
- DONE: select held, cpu_ack=1 for exactly this cycle, then IDLE with select cleared.
- FAULT:
  - cpu_err=1 for one cycle.
  - fault_address <= latched address; fault_valid <= 1.
  - fault_count increments, saturating at all-ones.
  - Then go to IDLE.
- Latency: request edge to ack is 1+W cycles. Minimum of 2 cycles between accepted requests, because IDLE is revisited between accesses.
- A request still high in the IDLE cycle after ack is accepted as a new access, so the master must drop cpu_req in the ack cycle.
- fault_clr, when no fault is being captured that cycle: clears fault_valid and fault_count; fault_address is retained.
- fault_clr in the same cycle as a FAULT capture: the capture wins, giving fault_valid=1 and fault_count=1.
- The region table is sampled only at acceptance; changes mid-access do not affect the current access.
- cpu_address changes after acceptance are ignored.

Test Plan:
- Reset/idle: assert rst mid-WAIT (W=3) -> select, cpu_ack and busy go 0 immediately; no ack after release; the next request behaves normally.
- Zero-wait hit: region0 0x0000-0x3fff W=0, request 0x1234 -> select=0x01 for 1 cycle, cpu_ack the cycle after the request edge, latency 1.
- Wait states: region5 0x5000-0x6fff W=2, request 0x5abc -> select=0x20 for 3 cycles, cpu_ack on the third, busy high for 3 cycles.
- Priority/overlap:
  - region1 0x4000-0x4fff, region2 0x4000-0x41ff; request 0x4100 -> select=0x02.
  - Disable region1; request 0x4100 -> select=0x04.
  - Request 0x4200 -> cpu_err.
- Unmapped: request 0x7fff -> cpu_err one cycle, fault_address=0x7fff, fault_valid=1, fault_count=1. Then 256 more faults -> fault_count=0xff saturated.
- Clear collision: fault_clr in the FAULT cycle of access 0x7ff0 -> fault_valid=1, fault_count=1, fault_address=0x7ff0. fault_clr alone afterwards -> valid=0, count=0, address retained.
